// File: rtl/contador_regressivo_mmss_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
package contador_pkg;

  localparam int DIGIT_W   = 4;
  localparam int SEC_U_MAX = 9;
  localparam int SEC_T_MAX = 5;
  localparam int MIN_U_MAX = 9;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic digit_t clamp_digit(digit_t d, digit_t mx);
    return (d > mx) ? mx : d;
  endfunction

endpackage

// File: rtl/contador_regressivo_mmss_if.sv
// Control, preset and display bus of the countdown timer; the timer is the slave.
interface contador_regressivo_mmss_if;
  import contador_pkg::*;

  logic   tick, load, start, stop;
  digit_t preset_min_t, preset_min_u, preset_sec_t, preset_sec_u;
  digit_t min_t, min_u, sec_t, sec_u;
  logic   running, zero, done;

  modport master (
    output tick, load, start, stop,
    output preset_min_t, preset_min_u, preset_sec_t, preset_sec_u,
    input  min_t, min_u, sec_t, sec_u, running, zero, done
  );

  modport slave (
    input  tick, load, start, stop,
    input  preset_min_t, preset_min_u, preset_sec_t, preset_sec_u,
    output min_t, min_u, sec_t, sec_u, running, zero, done
  );
endinterface

// File: rtl/contador_regressivo_mmss_digito.sv
// One BCD down-counter digit, modulo MAX+1; load wins over enable.
module digito_regressivo
  import contador_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en_i,
  input  logic   load_i,
  input  digit_t load_val_i,
  output digit_t q_o,
  output logic   borrow_o
);

  digit_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i)     q_d = load_val_i;
    else if (en_i)  q_d = (q_q == '0) ? digit_t'(MAX) : q_q - digit_t'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o      = q_q;
  assign borrow_o = en_i && (q_q == '0);

endmodule

// File: rtl/contador_regressivo_mmss.sv
// MM:SS countdown timer: four chained BCD down-digits plus an IDLE/RUN/PAUSE/DONE FSM.
// Optional periodic reload on expiry: define CONTADOR_AUTO_RELOAD_EN.
module contador_regressivo_mmss
  import contador_pkg::*;
#(
  parameter int MIN_TENS_MAX = 5
) (
  input logic clk,
  input logic reset,
  contador_regressivo_mmss_if.slave bus
);

  // Digit index: 0=sec_u, 1=sec_t, 2=min_u, 3=min_t
  localparam int MAXV [4] = '{SEC_U_MAX, SEC_T_MAX, MIN_U_MAX, MIN_TENS_MAX};

  state_t state_q, state_d;
  logic   done_q, done_d;
  logic   dec, reload, ld;
  logic   nonzero, last_sec;
  logic   [3:0] brw;
  digit_t [3:0] q, pre, ld_val;

  assign pre[0] = clamp_digit(bus.preset_sec_u, digit_t'(SEC_U_MAX));
  assign pre[1] = clamp_digit(bus.preset_sec_t, digit_t'(SEC_T_MAX));
  assign pre[2] = clamp_digit(bus.preset_min_u, digit_t'(MIN_U_MAX));
  assign pre[3] = clamp_digit(bus.preset_min_t, digit_t'(MIN_TENS_MAX));

`ifdef CONTADOR_AUTO_RELOAD_EN
  digit_t [3:0] shadow_q;
  logic         shadow_nz;

  always_ff @(posedge clk) begin
    if (!reset)        shadow_q <= '0;
    else if (bus.load) shadow_q <= pre;
  end

  assign shadow_nz = |shadow_q;
  assign ld_val    = bus.load ? pre : shadow_q;
`else
  assign ld_val    = pre;
`endif

  assign nonzero  = |q;
  assign last_sec = (q == {digit_t'(0), digit_t'(0), digit_t'(0), digit_t'(1)});
  assign ld       = bus.load | reload;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    dec     = 1'b0;
    reload  = 1'b0;
    if (bus.load) state_d = IDLE;
    else begin
      unique case (state_q)
        IDLE:  if (!bus.stop && bus.start && nonzero) state_d = RUN;
        RUN: begin
          if (bus.stop) state_d = PAUSE;
          else if (bus.tick && nonzero) begin
            dec = 1'b1;
            if (last_sec) begin
              done_d = 1'b1;
`ifdef CONTADOR_AUTO_RELOAD_EN
              if (shadow_nz) reload  = 1'b1;
              else           state_d = DONE;
`else
              state_d = DONE;
`endif
            end
          end
        end
        PAUSE: if (!bus.stop && bus.start) state_d = RUN;
        DONE:  ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Borrow ripples upward; min_t never borrows since dec is gated on a nonzero count.
  for (genvar i = 0; i < 4; i++) begin : g_dig
    digito_regressivo #(.MAX(MAXV[i])) u_dig (
      .clk        (clk),
      .reset      (reset),
      .en_i       ((i == 0) ? dec : brw[(i == 0) ? 0 : i-1]),
      .load_i     (ld),
      .load_val_i (ld_val[i]),
      .q_o        (q[i]),
      .borrow_o   (brw[i])
    );
  end

  assign bus.sec_u   = q[0];
  assign bus.sec_t   = q[1];
  assign bus.min_u   = q[2];
  assign bus.min_t   = q[3];
  assign bus.running = (state_q == RUN);
  assign bus.zero    = !nonzero;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_contador_regressivo_mmss.sv
// Directed self-checking bench for the MM:SS countdown timer.
module tb_contador_regressivo_mmss;
  import contador_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  contador_regressivo_mmss_if bus();

  contador_regressivo_mmss #(.MIN_TENS_MAX(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] dg();
    return {bus.min_t, bus.min_u, bus.sec_t, bus.sec_u};
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_load(input logic [15:0] v);
    {bus.preset_min_t, bus.preset_min_u, bus.preset_sec_t, bus.preset_sec_u} = v;
    bus.load = 1'b1; cyc(); bus.load = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    bus.tick = 1'b1; cyc(n); bus.tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; cyc(2); reset = 1'b1;
    n_cmp++; if (dg() !== 16'h0000) begin n_err++; $display("FAIL reset_digits got %h want 0000", dg()); end
    n_cmp++; if ({bus.running, bus.done, bus.zero} !== 3'b001) begin n_err++; $display("FAIL reset_flags got %b want 001", {bus.running, bus.done, bus.zero}); end
  endtask

  task automatic test_full_minute();
    do_load(16'h0100);
    n_cmp++; if (dg() !== 16'h0100 || bus.zero !== 1'b0) begin n_err++; $display("FAIL load_0100 got %h z=%b want 0100 z=0", dg(), bus.zero); end
    do_start();
    n_cmp++; if (bus.running !== 1'b1) begin n_err++; $display("FAIL start_run got %b want 1", bus.running); end
    do_ticks(1);
    n_cmp++; if (dg() !== 16'h0059) begin n_err++; $display("FAIL first_tick got %h want 0059", dg()); end
    do_ticks(58);
    n_cmp++; if (dg() !== 16'h0001 || bus.done !== 1'b0) begin n_err++; $display("FAIL at_0001 got %h d=%b want 0001 d=0", dg(), bus.done); end
    do_ticks(1);
`ifdef CONTADOR_AUTO_RELOAD_EN
    n_cmp++; if (dg() !== 16'h0100 || bus.done !== 1'b1 || bus.running !== 1'b1) begin n_err++; $display("FAIL expire_reload got %h d=%b r=%b want 0100 d=1 r=1", dg(), bus.done, bus.running); end
    cyc();
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL done_width got %b want 0", bus.done); end
`else
    n_cmp++; if (dg() !== 16'h0000 || bus.done !== 1'b1 || bus.running !== 1'b0 || bus.zero !== 1'b1) begin n_err++; $display("FAIL expire got %h d=%b r=%b z=%b want 0000 d=1 r=0 z=1", dg(), bus.done, bus.running, bus.zero); end
    cyc();
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL done_width got %b want 0", bus.done); end
    bus.tick = 1'b1; do_start(); bus.tick = 1'b0;
    n_cmp++; if (dg() !== 16'h0000 || bus.running !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL done_hold got %h r=%b d=%b want 0000 r=0 d=0", dg(), bus.running, bus.done); end
`endif
  endtask

  task automatic test_ripple();
    do_load(16'h1000); do_start(); do_ticks(1);
    n_cmp++; if (dg() !== 16'h0959) begin n_err++; $display("FAIL ripple got %h want 0959", dg()); end
  endtask

  task automatic test_pause();
    do_load(16'h0005); do_start(); do_ticks(2);
    n_cmp++; if (dg() !== 16'h0003) begin n_err++; $display("FAIL pre_pause got %h want 0003", dg()); end
    bus.stop = 1'b1; do_ticks(1); bus.stop = 1'b0;
    n_cmp++; if (dg() !== 16'h0003 || bus.running !== 1'b0) begin n_err++; $display("FAIL stop_tick got %h r=%b want 0003 r=0", dg(), bus.running); end
    do_ticks(3);
    n_cmp++; if (dg() !== 16'h0003) begin n_err++; $display("FAIL pause_hold got %h want 0003", dg()); end
    do_start();
    n_cmp++; if (bus.running !== 1'b1) begin n_err++; $display("FAIL resume got %b want 1", bus.running); end
    do_ticks(3);
`ifdef CONTADOR_AUTO_RELOAD_EN
    n_cmp++; if (dg() !== 16'h0005 || bus.done !== 1'b1) begin n_err++; $display("FAIL pause_expire got %h d=%b want 0005 d=1", dg(), bus.done); end
`else
    n_cmp++; if (dg() !== 16'h0000 || bus.done !== 1'b1) begin n_err++; $display("FAIL pause_expire got %h d=%b want 0000 d=1", dg(), bus.done); end
`endif
  endtask

  task automatic test_clamp_idle();
    do_load(16'hFCAB);
    n_cmp++; if (dg() !== 16'h5959) begin n_err++; $display("FAIL clamp got %h want 5959", dg()); end
    do_load(16'h0000); do_start();
    n_cmp++; if (bus.running !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL start_zero r=%b d=%b want 0 0", bus.running, bus.done); end
    do_load(16'h0003);
    bus.tick = 1'b1; do_start(); bus.tick = 1'b0;
    n_cmp++; if (dg() !== 16'h0003 || bus.running !== 1'b1) begin n_err++; $display("FAIL idle_tick got %h r=%b want 0003 r=1", dg(), bus.running); end
    bus.tick = 1'b1; do_load(16'h0042); bus.tick = 1'b0;
    n_cmp++; if (dg() !== 16'h0042 || bus.running !== 1'b0) begin n_err++; $display("FAIL load_prio got %h r=%b want 0042 r=0", dg(), bus.running); end
  endtask

  task automatic test_reset_mid();
    do_load(16'h0010); do_start(); do_ticks(3);
    n_cmp++; if (dg() !== 16'h0007) begin n_err++; $display("FAIL mid_run got %h want 0007", dg()); end
    reset = 1'b0; do_ticks(1); reset = 1'b1;
    n_cmp++; if (dg() !== 16'h0000 || bus.running !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL reset_mid got %h r=%b d=%b want 0000 0 0", dg(), bus.running, bus.done); end
    do_load(16'h0001); do_start();
    reset = 1'b0; do_ticks(1); reset = 1'b1;
    n_cmp++; if (bus.done !== 1'b0 || bus.zero !== 1'b1) begin n_err++; $display("FAIL reset_terminal d=%b z=%b want 0 1", bus.done, bus.zero); end
    cyc();
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_residual d=%b want 0", bus.done); end
  endtask

`ifdef CONTADOR_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    do_load(16'h0002); do_start(); do_ticks(2);
    n_cmp++; if (dg() !== 16'h0002 || bus.done !== 1'b1 || bus.running !== 1'b1) begin n_err++; $display("FAIL auto_reload got %h d=%b r=%b want 0002 1 1", dg(), bus.done, bus.running); end
  endtask
`endif

  initial begin
    bus.tick = 1'b0; bus.load = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    {bus.preset_min_t, bus.preset_min_u, bus.preset_sec_t, bus.preset_sec_u} = 16'h0000;
    #2;
    test_reset();
    test_full_minute();
    test_ripple();
    test_pause();
    test_clamp_idle();
    test_reset_mid();
`ifdef CONTADOR_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
